// File: rtl/operand_frame_collector_pkg.sv
// Shared types for the operand frame collector and its output register bank.
// A frame is eight operand words, X first, T last.
package operand_frame_pkg;

    localparam int OPW     = 32;
    localparam int NUM_OPS = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [IDX_W-1:0] {
        OP_X,
        OP_Y,
        OP_Z,
        OP_P,
        OP_Q,
        OP_R,
        OP_S,
        OP_T
    } op_idx_e;

    typedef logic [NUM_OPS-1:0][OPW-1:0] op_frame_t;

endpackage

// File: rtl/operand_frame_collector_if.sv
// Serial operand input stream plus parallel frame output with handshakes.
// master drives beats and out_ready; slave is the collector.
interface operand_frame_collector_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic             frame_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, frame_err,
        input  X, Y, Z, P, Q, R, S, T
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, frame_err,
        output X, Y, Z, P, Q, R, S, T
    );

endinterface

// File: rtl/operand_frame_collector_hold.sv
// Output register bank: holds a frame until downstream accepts it.
// A load in the same cycle as out_ready replaces the frame with no gap.
module frame_hold_reg
    import operand_frame_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  op_frame_t frame,
    input  logic      out_ready,
    output logic      out_valid,
    output op_frame_t data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data      <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            data      <= frame;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/operand_frame_collector.sv
// Assembles serial operand words into 8-word frames with a 2-deep
// (collect + hold) buffer; malformed frames are dropped and flagged.
module operand_frame_collector #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 8
) (
    input logic                      clk,
    input logic                      rst,
    operand_frame_collector_if.slave bus
);

    import operand_frame_pkg::*;

    if (NUM_OPS != 8) begin : g_bad_ops
        $error("operand_frame_collector: NUM_OPS must be 8");
    end
    if (WIDTH != OPW) begin : g_bad_width
        $error("operand_frame_collector: WIDTH must equal OPW");
    end

    logic [IDX_W-1:0] idx;
    op_frame_t        slots;
    logic             pending;
    logic             in_ready_q;
    logic             frame_err_q;

    logic             accept;
    logic             at_last_slot;
    logic             complete;
    logic             bad_frame;
    logic             out_free;
    logic             load;
    op_frame_t        load_frame;
    logic             out_valid;
    op_frame_t        hold_data;

    assign accept       = bus.in_valid && in_ready_q;
    assign at_last_slot = (idx == OP_T);
    assign complete     = accept && bus.in_last && at_last_slot;
    assign bad_frame    = accept && (bus.in_last != at_last_slot);
    assign out_free     = !out_valid || bus.out_ready;

    // A pending frame already has its last word parked in slot T.
    always_comb begin
        load_frame = slots;
        load       = 1'b0;
        if (pending) begin
            load = out_free;
        end else if (complete) begin
            load             = out_free;
            load_frame[OP_T] = bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            slots       <= '0;
            pending     <= 1'b0;
            in_ready_q  <= 1'b1;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= bad_frame;
            if (accept) begin
                slots[idx] <= bus.in_data;
                if (bad_frame || complete) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (pending && out_free) begin
                pending    <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (complete && !out_free) begin
                pending    <= 1'b1;
                in_ready_q <= 1'b0;
            end
        end
    end

    frame_hold_reg u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .frame     (load_frame),
        .out_ready (bus.out_ready),
        .out_valid (out_valid),
        .data      (hold_data)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.frame_err = frame_err_q;
    assign bus.X         = hold_data[OP_X];
    assign bus.Y         = hold_data[OP_Y];
    assign bus.Z         = hold_data[OP_Z];
    assign bus.P         = hold_data[OP_P];
    assign bus.Q         = hold_data[OP_Q];
    assign bus.R         = hold_data[OP_R];
    assign bus.S         = hold_data[OP_S];
    assign bus.T         = hold_data[OP_T];

endmodule

// File: tb/tb_operand_frame_collector.sv
// Scoreboard bench for operand_frame_collector: directed cases then
// randomized streams with stalls and malformed frames.
module tb_operand_frame_collector;

    import operand_frame_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    operand_frame_collector_if #(.WIDTH(OPW)) bus ();

    operand_frame_collector #(
        .WIDTH   (OPW),
        .NUM_OPS (NUM_OPS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int err_exp  = 0;
    int err_seen = 0;
    bit rand_ready = 1'b0;

    op_frame_t        exp_q[$];
    logic [OPW-1:0]   cur[$];

    function automatic op_frame_t dut_frame();
        return {bus.T, bus.S, bus.R, bus.Q, bus.P, bus.Z, bus.Y, bus.X};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input op_frame_t act,
                               input op_frame_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a frame is good only if in_last falls exactly on word 8.
    task automatic model_beat(input logic [OPW-1:0] d, input bit last);
        op_frame_t fr;
        cur.push_back(d);
        if (last) begin
            if (cur.size() == NUM_OPS) begin
                for (int i = 0; i < NUM_OPS; i++) fr[i] = cur[i];
                exp_q.push_back(fr);
            end else begin
                err_exp++;
            end
            cur.delete();
        end else if (cur.size() == NUM_OPS) begin
            err_exp++;
            cur.delete();
        end
    endtask

    task automatic send_beat(input logic [OPW-1:0] d, input bit last);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 2000) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                break;
            end
        end
        if (bus.in_ready) model_beat(d, last);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_seq(input int first, input int n, input int last_at);
        for (int i = 0; i < n; i++)
            send_beat(OPW'(first + i), (i + 1) == last_at);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        cur.delete();
        rst = 1'b0;
    endtask

    // Monitor: pops on every output handshake and checks hold stability.
    initial begin
        op_frame_t held;
        bit        have_held;
        have_held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_held = 1'b0;
                continue;
            end
            if (bus.frame_err) err_seen++;
            if (have_held) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check_frame("hold_data", dut_frame(), held);
            end
            have_held = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got X=%0h expected none",
                             bus.X);
                end else begin
                    check_frame("frame", dut_frame(), exp_q.pop_front());
                end
            end else if (bus.out_valid) begin
                held      = dut_frame();
                have_held = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int waited;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // 1: reset values and a single clean frame
        do_reset();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_frame_err", 64'(bus.frame_err), 64'd0);
        check_frame("rst_data", dut_frame(), '0);
        bus.out_ready = 1'b1;
        send_seq(1, 8, 8);
        check("t1_out_valid", 64'(bus.out_valid), 64'd1);
        check("t1_X", 64'(bus.X), 64'd1);
        check("t1_T", 64'(bus.T), 64'd8);
        idle(2);
        check("t1_no_err", 64'(err_seen), 64'd0);

        // 2: second frame completes while the first is held
        bus.out_ready = 1'b0;
        send_seq(1, 8, 8);
        send_seq(9, 8, 8);
        check("t2_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("t2_X_held", 64'(bus.X), 64'd1);
        idle(3);
        check("t2_X_still", 64'(bus.X), 64'd1);
        bus.out_ready = 1'b1;
        idle(1);
        check("t2_no_gap", 64'(bus.out_valid), 64'd1);
        check("t2_X_next", 64'(bus.X), 64'd9);
        check("t2_T_next", 64'(bus.T), 64'd16);
        check("t2_in_ready_back", 64'(bus.in_ready), 64'd1);
        idle(1);
        check("t2_drained", 64'(bus.out_valid), 64'd0);

        // 3: early in_last
        send_seq(1, 5, 5);
        check("t3_err_pulse", 64'(bus.frame_err), 64'd1);
        idle(1);
        check("t3_err_single", 64'(bus.frame_err), 64'd0);
        send_seq(21, 8, 8);
        check("t3_X", 64'(bus.X), 64'd21);
        check("t3_err_count", 64'(err_seen), 64'd1);

        // 4: missing in_last
        send_seq(100, 8, 0);
        check("t4_err_pulse", 64'(bus.frame_err), 64'd1);
        send_seq(31, 8, 8);
        check("t4_X", 64'(bus.X), 64'd31);
        check("t4_err_count", 64'(err_seen), 64'd2);

        // 5: reset with a held frame and a partial frame
        idle(2);
        bus.out_ready = 1'b0;
        send_seq(41, 8, 8);
        send_seq(51, 4, 0);
        do_reset();
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        check_frame("t5_data", dut_frame(), '0);
        idle(1);
        check("t5_no_err", 64'(bus.frame_err), 64'd0);
        bus.out_ready = 1'b1;
        send_seq(61, 8, 8);
        check("t5_X", 64'(bus.X), 64'd61);
        check("t5_T", 64'(bus.T), 64'd68);
        idle(2);
        check("t5_err_count", 64'(err_seen), 64'(err_exp));

        // 6: random stalls with occasional malformed frames
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 19));
            len  = (kind == 0) ? int'($urandom_range(1, 7)) : 8;
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                send_beat($urandom, (kind != 1) && (b == len - 1));
            end
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            idle(1);
            waited++;
        end
        idle(2);
        check("t6_drained", 64'(exp_q.size()), 64'd0);
        check("t6_err_count", 64'(err_seen), 64'(err_exp));
        check("t6_in_ready", 64'(bus.in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
